btb_update_queue: RTL

Write-side feeder for the branch target buffer. It collects up to two committed taken branches per cycle from the commit stage, filters redundant updates, and buffers them in a small in-order FIFO. It drains at most one entry per cycle onto the BTB's single write port (`we`/`jmpsrc`/`jmpdst`). It sits between commit and the BTB and absorbs dual-commit bursts that the one-port BTB cannot take directly.

---
 rtl/btb_update_queue_pkg.sv | 16 +
 rtl/btbq_filter.sv | 62 ++++++
 rtl/btb_update_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/btb_update_queue_pkg.sv
// btb_update_queue_pkg: shared constants and types
// for the BTB write-side update queue.
package btb_update_queue_pkg;

    localparam int ADDR_LEN    = 32;
    localparam int BTB_IDX_SEL = 8;
    localparam int BTBQ_DEPTH  = 4;

    typedef logic [ADDR_LEN-1:0] addr_t;

    typedef struct packed {
        addr_t src;
        addr_t dst;
    } btbq_entry_t;

endpackage

// File: rtl/btbq_filter.sv
// btbq_filter: same-cycle merge and repeat filtering
// of the two commit slots ahead of the FIFO.
module btbq_filter
    import btb_update_queue_pkg::*;
(
    input  logic        brvalid1,
    input  logic        brtaken1,
    input  addr_t       brsrc1,
    input  addr_t       brdst1,
    input  logic        brvalid2,
    input  logic        brtaken2,
    input  addr_t       brsrc2,
    input  addr_t       brdst2,
    input  logic        last_vld,
    input  addr_t       last_src,
    input  addr_t       last_dst,
    input  logic        slot1_room,
    output logic        cand1,
    output logic        cand2,
    output btbq_entry_t ent1,
    output btbq_entry_t ent2
);

    logic  t1;
    logic  t2;
    logic  merge;
    logic  rep1;
    logic  rep2;
    logic  prev_vld;
    addr_t prev_src;
    addr_t prev_dst;

    // Slot 2 is judged against slot 1 when slot 1 lands this cycle,
    // otherwise against the last entry actually enqueued.
    always_comb begin
        t1    = brvalid1 & brtaken1;
        t2    = brvalid2 & brtaken2;
        merge = t1 & t2 & (brsrc1 == brsrc2);
        rep1  = last_vld & (brsrc1 == last_src)
              & (brdst1 == last_dst);
        cand1 = t1 & ~merge & ~rep1;

        prev_vld = last_vld;
        prev_src = last_src;
        prev_dst = last_dst;
        if (cand1 && slot1_room) begin
            prev_vld = 1'b1;
            prev_src = brsrc1;
            prev_dst = brdst1;
        end

        rep2  = prev_vld & (brsrc2 == prev_src)
              & (brdst2 == prev_dst);
        cand2 = t2 & ~rep2;

        ent1.src = brsrc1;
        ent1.dst = brdst1;
        ent2.src = brsrc2;
        ent2.dst = brdst2;
    end

endmodule

// File: rtl/btb_update_queue.sv
// btb_update_queue: dual-enqueue, single-drain FIFO
// feeding the one-port BTB write interface.
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH = BTBQ_DEPTH,
    parameter int PTR_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                brvalid1,
    input  logic                brtaken1,
    input  logic [ADDR_LEN-1:0] brsrc1,
    input  logic [ADDR_LEN-1:0] brdst1,
    input  logic                brvalid2,
    input  logic                brtaken2,
    input  logic [ADDR_LEN-1:0] brsrc2,
    input  logic [ADDR_LEN-1:0] brdst2,
    input  logic                flush,
    output logic                we,
    output logic [ADDR_LEN-1:0] jmpsrc,
    output logic [ADDR_LEN-1:0] jmpdst,
    output logic                full,
    output logic [PTR_W:0]      count,
    output logic                ovf,
    output logic [CNT_W-1:0]    drop_cnt
);

    btbq_entry_t mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             last_vld;
    addr_t            last_src;
    addr_t            last_dst;

    logic             pop;
    logic [PTR_W+1:0] space;
    logic             slot1_room;
    logic             cand1;
    logic             cand2;
    btbq_entry_t      ent1;
    btbq_entry_t      ent2;
    logic             acc1;
    logic             acc2;
    logic             drop1;
    logic             drop2;
    logic [1:0]       n_drop;
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W-1:0] drop_next;
    logic [PTR_W-1:0] tail2;
    logic [PTR_W:0]   count_next;

    btbq_filter u_filter (
        .brvalid1   (brvalid1),
        .brtaken1   (brtaken1),
        .brsrc1     (brsrc1),
        .brdst1     (brdst1),
        .brvalid2   (brvalid2),
        .brtaken2   (brtaken2),
        .brsrc2     (brsrc2),
        .brdst2     (brdst2),
        .last_vld   (last_vld),
        .last_src   (last_src),
        .last_dst   (last_dst),
        .slot1_room (slot1_room),
        .cand1      (cand1),
        .cand2      (cand2),
        .ent1       (ent1),
        .ent2       (ent2)
    );

    assign full = (count == (PTR_W+1)'(DEPTH));

    // Space accounting: a pop this edge frees one slot for the enqueue.
    always_comb begin
        pop        = (count != '0);
        space      = (PTR_W+2)'(DEPTH) - {1'b0, count}
                   + (PTR_W+2)'(pop);
        slot1_room = (space != '0);
        acc1       = ~flush & cand1 & slot1_room;
        acc2       = ~flush & cand2
                   & (space >= (acc1 ? (PTR_W+2)'(2) : (PTR_W+2)'(1)));
        drop1      = ~flush & cand1 & ~acc1;
        drop2      = ~flush & cand2 & ~acc2;
        n_drop     = {1'b0, drop1} + {1'b0, drop2};
        drop_sum   = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);
        drop_next  = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        tail2      = tail + PTR_W'(acc1);
        count_next = count - (PTR_W+1)'(pop)
                   + (PTR_W+1)'(acc1) + (PTR_W+1)'(acc2);
    end

    // Entry storage; up to two writes per edge at the tail.
    always_ff @(posedge clk) begin
        if (acc1) mem[tail]  <= ent1;
        if (acc2) mem[tail2] <= ent2;
    end

    // Pointers, occupancy, repeat-filter state and drop statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            last_vld <= 1'b0;
            last_src <= '0;
            last_dst <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            last_vld <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (pop) head <= head + 1'b1;
            tail     <= tail + PTR_W'(acc1) + PTR_W'(acc2);
            count    <= count_next;
            ovf      <= (n_drop != 2'd0);
            drop_cnt <= drop_next;
            if (acc2) begin
                last_vld <= 1'b1;
                last_src <= ent2.src;
                last_dst <= ent2.dst;
            end else if (acc1) begin
                last_vld <= 1'b1;
                last_src <= ent1.src;
                last_dst <= ent1.dst;
            end
        end
    end

    // Registered BTB write port; head moves out on every pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we     <= 1'b0;
            jmpsrc <= '0;
            jmpdst <= '0;
        end else if (flush) begin
            we <= 1'b0;
        end else if (pop) begin
            we     <= 1'b1;
            jmpsrc <= mem[head].src;
            jmpdst <= mem[head].dst;
        end else begin
            we <= 1'b0;
        end
    end

endmodule
